// File: rtl/gun_pos_ctrl_pkg.sv
// Shared types and default configuration for the light-gun position controller.
package gun_pkg;

  localparam int POS_W       = 6;
  localparam int POS_MAX     = 63;
  localparam int CENTER      = 32;
  localparam int ACCEL_TICKS = 8;
  localparam int MAX_SPEED   = 4;

  localparam int SPEED_W = $clog2(MAX_SPEED + 1);
  localparam int HOLD_W  = $clog2(ACCEL_TICKS + 1);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } dir_t;

  // Per-axis state at the default configuration.
  typedef struct packed {
    logic [POS_W-1:0]   pos;
    logic [SPEED_W-1:0] speed;
    logic [HOLD_W-1:0]  hold;
    dir_t               last_dir;
  } axis_state_t;

endpackage

// File: rtl/gun_pos_ctrl_if.sv
// Joystick/tick inputs and gun coordinate outputs of gun_pos_ctrl.
// GUN_ANALOG_EN adds the analog stick inputs.
interface gun_pos_ctrl_if #(parameter int POS_W = gun_pkg::POS_W);
  logic             tick_4ms;
  logic             joy_up;
  logic             joy_down;
  logic             joy_left;
  logic             joy_right;
  logic             recenter;
  logic [POS_W-1:0] gun_h;
  logic [POS_W-1:0] gun_v;
  logic [1:0]       gun_moving;
`ifdef GUN_ANALOG_EN
  logic signed [7:0] analog_x;
  logic signed [7:0] analog_y;
  logic              analog_sel;
`endif

  modport master (
    output tick_4ms, joy_up, joy_down, joy_left, joy_right, recenter,
`ifdef GUN_ANALOG_EN
    output analog_x, analog_y, analog_sel,
`endif
    input  gun_h, gun_v, gun_moving
  );

  modport slave (
    input  tick_4ms, joy_up, joy_down, joy_left, joy_right, recenter,
`ifdef GUN_ANALOG_EN
    input  analog_x, analog_y, analog_sel,
`endif
    output gun_h, gun_v, gun_moving
  );
endinterface

// File: rtl/gun_pos_ctrl_axis.sv
// One gun axis: direction decode, hold-to-accelerate stepping, edge clamping.
// GUN_ANALOG_EN adds slewing toward an analog target.
module gun_axis #(
  parameter int POS_W       = gun_pkg::POS_W,
  parameter int POS_MAX     = gun_pkg::POS_MAX,
  parameter int CENTER      = gun_pkg::CENTER,
  parameter int ACCEL_TICKS = gun_pkg::ACCEL_TICKS,
  parameter int MAX_SPEED   = gun_pkg::MAX_SPEED
) (
  input  logic              clock_12,
  input  logic              reset,
  input  logic              tick,
  input  logic              recenter,
  input  logic              inc,
  input  logic              dec,
`ifdef GUN_ANALOG_EN
  input  logic signed [7:0] analog,
  input  logic              analog_sel,
`endif
  output logic [POS_W-1:0]  pos,
  output logic              moving
);
  import gun_pkg::*;

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  // Wide enough for POS_MAX + MAX_SPEED and for the sign-extended analog offset.
  localparam int AW = (POS_W + 2 > 10) ? POS_W + 2 : 10;

  localparam logic [POS_W-1:0]     CENTER_P  = POS_W'(CENTER);
  localparam logic [POS_W-1:0]     POS_MAX_P = POS_W'(POS_MAX);
  localparam logic signed [AW-1:0] MAX_S     = AW'(POS_MAX);
  localparam logic [SW-1:0]        SPEED_ONE = SW'(1);
  localparam logic [SW-1:0]        SPEED_MAX = SW'(MAX_SPEED);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(ACCEL_TICKS - 1);

  logic [POS_W-1:0] pos_reg;
  logic [SW-1:0]    speed_reg;
  logic [HW-1:0]    hold_reg;
  dir_t             last_dir_reg;
  logic             moving_reg;

  dir_t                  dir;
  logic                  restart;
  logic [SW-1:0]         speed_base, speed_next;
  logic [HW-1:0]         hold_base, hold_next;
  logic signed [AW-1:0]  pos_ext, speed_ext, sum;
  logic [POS_W-1:0]      pos_next;

  function automatic logic [POS_W-1:0] clamp(input logic signed [AW-1:0] v);
    if (v[AW-1])
      return '0;
    else if (v > MAX_S)
      return POS_MAX_P;
    else
      return v[POS_W-1:0];
  endfunction

`ifdef GUN_ANALOG_EN
  logic                 sel_q;
  logic                 sel_changed;
  logic signed [AW-1:0] ana_ext, tgt_ext, diff, slew;
  logic [POS_W-1:0]     target, slew_pos;
  localparam logic signed [AW-1:0] STEP_S   = AW'(MAX_SPEED);
  localparam logic signed [AW-1:0] CENTER_S = AW'(CENTER);

  assign sel_changed = analog_sel != sel_q;

  always_comb begin
    ana_ext = {{(AW-6){analog[7]}}, analog[7:2]};
    target  = clamp(CENTER_S + ana_ext);
    tgt_ext = {{(AW-POS_W){1'b0}}, target};
    diff    = tgt_ext - pos_ext;
    slew    = tgt_ext;
    if (diff > STEP_S)
      slew = pos_ext + STEP_S;
    else if (diff < -STEP_S)
      slew = pos_ext - STEP_S;
    slew_pos = clamp(slew);
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset)
      sel_q <= 1'b0;
    else
      sel_q <= analog_sel;
  end
`endif

  always_comb begin
    dir = NONE;
    if (inc && !dec)
      dir = INC;
    else if (dec && !inc)
      dir = DEC;
`ifdef GUN_ANALOG_EN
    restart = (dir != last_dir_reg) || sel_changed;
`else
    restart = (dir != last_dir_reg);
`endif
    speed_base = restart ? SPEED_ONE : speed_reg;
    hold_base  = restart ? '0 : hold_reg;
    pos_ext    = {{(AW-POS_W){1'b0}}, pos_reg};
    speed_ext  = {{(AW-SW){1'b0}}, speed_base};
    sum        = (dir == DEC) ? pos_ext - speed_ext : pos_ext + speed_ext;
    pos_next   = clamp(sum);
    if (hold_base == HOLD_LAST) begin
      hold_next  = '0;
      speed_next = (speed_base >= SPEED_MAX) ? SPEED_MAX : speed_base + SW'(1);
    end else begin
      hold_next  = hold_base + HW'(1);
      speed_next = speed_base;
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset || recenter) begin
      pos_reg      <= CENTER_P;
      speed_reg    <= SPEED_ONE;
      hold_reg     <= '0;
      last_dir_reg <= NONE;
      moving_reg   <= 1'b0;
`ifdef GUN_ANALOG_EN
    end else if (analog_sel) begin
      speed_reg    <= SPEED_ONE;
      hold_reg     <= '0;
      last_dir_reg <= NONE;
      if (tick) begin
        pos_reg    <= slew_pos;
        moving_reg <= (slew_pos != pos_reg);
      end
    end else if (sel_changed && !tick) begin
      speed_reg    <= SPEED_ONE;
      hold_reg     <= '0;
      last_dir_reg <= NONE;
`endif
    end else if (tick) begin
      if (dir == NONE) begin
        speed_reg    <= SPEED_ONE;
        hold_reg     <= '0;
        last_dir_reg <= NONE;
        moving_reg   <= 1'b0;
      end else begin
        pos_reg      <= pos_next;
        speed_reg    <= speed_next;
        hold_reg     <= hold_next;
        last_dir_reg <= dir;
        moving_reg   <= (pos_next != pos_reg);
      end
    end
  end

  assign pos    = pos_reg;
  assign moving = moving_reg;

endmodule

// File: rtl/gun_pos_ctrl.sv
// Joystick-to-light-gun coordinate controller: 4 ms tick edge detect plus two axes.
// GUN_ANALOG_EN enables analog stick positioning.
module gun_pos_ctrl #(
  parameter int POS_W       = gun_pkg::POS_W,
  parameter int POS_MAX     = gun_pkg::POS_MAX,
  parameter int CENTER      = gun_pkg::CENTER,
  parameter int ACCEL_TICKS = gun_pkg::ACCEL_TICKS,
  parameter int MAX_SPEED   = gun_pkg::MAX_SPEED
) (
  input  logic         clock_12,
  input  logic         reset,
  gun_pos_ctrl_if.slave bus
);

  logic tick_q;
  logic tick;

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset)
      tick_q <= 1'b0;
    else
      tick_q <= bus.tick_4ms;
  end

  assign tick = bus.tick_4ms & ~tick_q;

  // Index 0 is the horizontal axis, index 1 the vertical axis.
  logic             inc_a [2];
  logic             dec_a [2];
  logic [POS_W-1:0] pos_a [2];
  logic [1:0]       moving_a;

  assign inc_a[0] = bus.joy_right;
  assign dec_a[0] = bus.joy_left;
  assign inc_a[1] = bus.joy_down;
  assign dec_a[1] = bus.joy_up;

`ifdef GUN_ANALOG_EN
  logic signed [7:0] analog_a [2];
  assign analog_a[0] = bus.analog_x;
  assign analog_a[1] = bus.analog_y;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      gun_axis #(
        .POS_W       (POS_W),
        .POS_MAX     (POS_MAX),
        .CENTER      (CENTER),
        .ACCEL_TICKS (ACCEL_TICKS),
        .MAX_SPEED   (MAX_SPEED)
      ) u_axis (
        .clock_12   (clock_12),
        .reset      (reset),
        .tick       (tick),
        .recenter   (bus.recenter),
        .inc        (inc_a[gi]),
        .dec        (dec_a[gi]),
`ifdef GUN_ANALOG_EN
        .analog     (analog_a[gi]),
        .analog_sel (bus.analog_sel),
`endif
        .pos        (pos_a[gi]),
        .moving     (moving_a[gi])
      );
    end
  endgenerate

  assign bus.gun_h      = pos_a[0];
  assign bus.gun_v      = pos_a[1];
  assign bus.gun_moving = moving_a;

endmodule

// File: tb/tb_gun_pos_ctrl.sv
// Directed bench for gun_pos_ctrl at default parameters (digital build).
module tb_gun_pos_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gun_pos_ctrl_if bus ();

  gun_pos_ctrl dut (
    .clock_12 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int tick_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int h, input int v, input int mv);
    check({tag, "_h"},  32'(bus.gun_h), h);
    check({tag, "_v"},  32'(bus.gun_v), v);
    check({tag, "_mv"}, 32'(bus.gun_moving), mv);
  endtask

  // Tick level held high for two cycles: only its rising edge may count.
  task automatic tick_once();
    @(posedge clk); #1 bus.tick_4ms = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.tick_4ms = 1'b0;
    @(posedge clk); #1;
    tick_n++;
    $display("tick %0d: h=%0d v=%0d moving=%b", tick_n, bus.gun_h, bus.gun_v, bus.gun_moving);
  endtask

  task automatic set_joy(input logic u, input logic d, input logic l, input logic r);
    bus.joy_up = u; bus.joy_down = d; bus.joy_left = l; bus.joy_right = r;
  endtask

  initial begin
    int exp_h [9];
    int e;
    exp_h = '{33, 34, 35, 36, 37, 38, 39, 40, 42};
    bus.tick_4ms = 1'b0;
    bus.recenter = 1'b0;
    set_joy(0, 0, 0, 0);

    #22 check_all("reset", 32, 32, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick_once();
      check_all("idle", 32, 32, 0);
    end

    set_joy(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      tick_once();
      check_all("right_accel", exp_h[i], 32, 1);
    end
    set_joy(0, 0, 0, 0);
    tick_once();
    check_all("right_release", 42, 32, 0);

    set_joy(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (i < 8)       e = 31 - i;
      else if (i < 16) e = 22 - 2 * (i - 8);
      else if (i == 16) e = 5;
      else if (i == 17) e = 2;
      else             e = 0;
      tick_once();
      check_all("up_clamp", 42, e, (i <= 18) ? 2 : 0);
    end
    set_joy(0, 0, 0, 0);
    tick_once();

    set_joy(0, 0, 1, 0);
    tick_once();
    tick_once();
    check_all("left_to_40", 40, 0, 1);
    set_joy(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick_once();
      check_all("both_held", 40, 0, 0);
    end
    set_joy(0, 0, 0, 1);
    tick_once();
    check_all("right_after_both", 41, 0, 1);

    set_joy(0, 0, 0, 0);
    @(posedge clk); #1 bus.recenter = 1'b1;
    @(posedge clk); #1 bus.recenter = 1'b0;
    check_all("recenter_plain", 32, 32, 0);

    set_joy(0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      tick_once();
      if (i == 7)  check("r17_t8_h",  32'(bus.gun_h), 40);
      if (i == 15) check("r17_t16_h", 32'(bus.gun_h), 56);
    end
    check_all("right17", 59, 32, 1);
    set_joy(0, 0, 1, 0);
    tick_once();
    check_all("first_left", 58, 32, 1);
    for (int i = 0; i < 7; i++) tick_once();
    check("left_to_51", 32'(bus.gun_h), 51);
    set_joy(0, 0, 0, 0);
    tick_once();
    set_joy(0, 0, 1, 0);
    tick_once();
    check_all("at_50", 50, 32, 1);

    @(posedge clk); #1 bus.tick_4ms = 1'b1; bus.recenter = 1'b1;
    @(posedge clk); #1 bus.recenter = 1'b0;
    check_all("recenter_tick", 32, 32, 0);
    @(posedge clk); #1 bus.tick_4ms = 1'b0; set_joy(0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    check_all("recenter_hold", 32, 32, 0);

    set_joy(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) tick_once();
    check_all("premove", 44, 32, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_all("async_reset", 32, 32, 0);
    #2 rst = 1'b0;
    tick_once();
    check_all("post_reset_1", 33, 32, 1);
    tick_once();
    check_all("post_reset_2", 34, 32, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
